// File: rtl/player_hit_judge_if.sv
// Bundle between the game-logic driver and player_hit_judge: bullet and player
// positions, tick/restart controls, and the player status outputs.
interface player_hit_judge_if;
  logic       tick;
  logic [9:0] eb_x;
  logic [9:0] eb_y;
  logic       enemybullet_exist;
  logic [9:0] p_x;
  logic [9:0] p_y;
  logic       restart;
  logic       boom;
  logic [1:0] lives;
  logic       player_visible;
  logic       invincible;
  logic [1:0] explode_frame;
  logic       game_over;

  modport master (
    output tick, eb_x, eb_y, enemybullet_exist, p_x, p_y, restart,
    input  boom, lives, player_visible, invincible, explode_frame, game_over
  );

  modport slave (
    input  tick, eb_x, eb_y, enemybullet_exist, p_x, p_y, restart,
    output boom, lives, player_visible, invincible, explode_frame, game_over
  );
endinterface

// File: rtl/player_hit_judge.sv
// Enemy-bullet vs player collision judge: raises boom on a hit and tracks lives,
// explosion animation, post-respawn invulnerability and game over.
module player_hit_judge #(
  parameter int BULLET_W      = 10,
  parameter int BULLET_H      = 40,
  parameter int PLAYER_W      = 46,
  parameter int PLAYER_H      = 40,
  parameter int Y_OFFSET      = 480,
  parameter int INIT_LIVES    = 3,
  parameter int EXPLODE_TICKS = 32,
  parameter int INVULN_TICKS  = 120
) (
  input  logic               clk,
  input  logic               rst,
  player_hit_judge_if.slave  bus
);

  localparam int CNT_MAX = (EXPLODE_TICKS > INVULN_TICKS) ? EXPLODE_TICKS : INVULN_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int QUARTER = EXPLODE_TICKS / 4;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    EXPLODE = 2'd1,
    INVULN  = 2'd2,
    DEAD    = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         lives_reg;
  logic               boom_reg;
  logic               player_visible_reg;
  logic               invincible_reg;
  logic [1:0]         explode_frame_reg;
  logic               game_over_reg;

  // Axis 0 is x, axis 1 is y. Everything lives in 11 bits so the sums never wrap;
  // the player's y is moved into the bullet's offset vertical space.
  logic [10:0] bul_lo [2];
  logic [10:0] ply_lo [2];
  logic [1:0]  axis_overlap;
  logic        hit;

  assign bul_lo[0] = {1'b0, bus.eb_x};
  assign bul_lo[1] = {1'b0, bus.eb_y};
  assign ply_lo[0] = {1'b0, bus.p_x};
  assign ply_lo[1] = {1'b0, bus.p_y} + 11'(Y_OFFSET);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic [10:0] BUL_LEN = 11'((gi == 0) ? BULLET_W : BULLET_H);
      localparam logic [10:0] PLY_LEN = 11'((gi == 0) ? PLAYER_W : PLAYER_H);
      // Half-open intervals: touching edges do not overlap.
      assign axis_overlap[gi] = (bul_lo[gi] < (ply_lo[gi] + PLY_LEN)) &&
                                (ply_lo[gi] < (bul_lo[gi] + BUL_LEN));
    end
  endgenerate

  assign hit = (&axis_overlap) && bus.enemybullet_exist;

  logic [CNT_W-1:0] cnt_next;
  logic [1:0]       frame_next;
  logic             explode_last;
  logic             invuln_last;

  assign cnt_next     = cnt_reg + CNT_W'(1);
  assign frame_next   = 2'(cnt_next / CNT_W'(QUARTER));
  assign explode_last = (cnt_reg == CNT_W'(EXPLODE_TICKS - 1));
  assign invuln_last  = (cnt_reg == CNT_W'(INVULN_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ALIVE;
      cnt_reg            <= '0;
      lives_reg          <= 2'(INIT_LIVES);
      boom_reg           <= 1'b0;
      player_visible_reg <= 1'b1;
      invincible_reg     <= 1'b0;
      explode_frame_reg  <= 2'd0;
      game_over_reg      <= 1'b0;
    end else begin
      boom_reg <= 1'b0;
      case (state_reg)
        ALIVE: begin
          // Leaving ALIVE immediately guarantees a single boom for a held hit.
          if (bus.tick && hit) begin
            state_reg          <= EXPLODE;
            boom_reg           <= 1'b1;
            lives_reg          <= lives_reg - 2'd1;
            cnt_reg            <= '0;
            explode_frame_reg  <= 2'd0;
            player_visible_reg <= 1'b0;
          end
        end
        EXPLODE: begin
          if (bus.tick) begin
            if (explode_last) begin
              cnt_reg           <= '0;
              explode_frame_reg <= 2'd0;
              if (lives_reg == 2'd0) begin
                state_reg     <= DEAD;
                game_over_reg <= 1'b1;
              end else begin
                state_reg          <= INVULN;
                invincible_reg     <= 1'b1;
                player_visible_reg <= 1'b1;
              end
            end else begin
              cnt_reg           <= cnt_next;
              explode_frame_reg <= frame_next;
            end
          end
        end
        INVULN: begin
          if (bus.tick) begin
            if (invuln_last) begin
              state_reg      <= ALIVE;
              cnt_reg        <= '0;
              invincible_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_next;
            end
          end
        end
        DEAD: begin
          if (bus.restart) begin
            state_reg          <= ALIVE;
            cnt_reg            <= '0;
            lives_reg          <= 2'(INIT_LIVES);
            game_over_reg      <= 1'b0;
            player_visible_reg <= 1'b1;
          end
        end
        default: state_reg <= ALIVE;
      endcase
    end
  end

  assign bus.boom           = boom_reg;
  assign bus.lives          = lives_reg;
  assign bus.player_visible = player_visible_reg;
  assign bus.invincible     = invincible_reg;
  assign bus.explode_frame  = explode_frame_reg;
  assign bus.game_over      = game_over_reg;

endmodule

// File: tb/tb_player_hit_judge.sv
// Directed bench for player_hit_judge: hit geometry, explosion/invulnerability
// timeline, game over/restart and reset behaviour.
module tb_player_hit_judge;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  player_hit_judge_if bus ();

  player_hit_judge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One clock: inputs change at negedge, outputs read 1 ns after posedge.
  task automatic step(input logic t, input logic r);
    @(negedge clk);
    bus.tick    = t;
    bus.restart = r;
    @(posedge clk);
    #1;
    bus.tick    = 1'b0;
    bus.restart = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_geom(input int bx, input int by, input logic ex, input int px, input int py);
    bus.eb_x              = 10'(bx);
    bus.eb_y              = 10'(by);
    bus.enemybullet_exist = ex;
    bus.p_x               = 10'(px);
    bus.p_y               = 10'(py);
  endtask

  task automatic test_reset();
    set_geom(100, 500, 1'b1, 95, 15);
    bus.tick = 1'b1;
    do_reset();
    bus.tick = 1'b0;
    total += 6;
    if (bus.boom !== 1'b0)           begin bad++; $display("FAIL reset_boom: got %b want 0", bus.boom); end
    if (bus.lives !== 2'd3)          begin bad++; $display("FAIL reset_lives: got %0d want 3", bus.lives); end
    if (bus.player_visible !== 1'b1) begin bad++; $display("FAIL reset_visible: got %b want 1", bus.player_visible); end
    if (bus.invincible !== 1'b0)     begin bad++; $display("FAIL reset_invincible: got %b want 0", bus.invincible); end
    if (bus.explode_frame !== 2'd0)  begin bad++; $display("FAIL reset_frame: got %0d want 0", bus.explode_frame); end
    if (bus.game_over !== 1'b0)      begin bad++; $display("FAIL reset_game_over: got %b want 0", bus.game_over); end
    $display("test_reset: lives=%0d visible=%b", bus.lives, bus.player_visible);
  endtask

  task automatic test_single_hit();
    do_reset();
    set_geom(100, 500, 1'b1, 95, 15);
    step(1'b1, 1'b0);
    total += 4;
    if (bus.boom !== 1'b1)           begin bad++; $display("FAIL hit_boom: got %b want 1", bus.boom); end
    if (bus.lives !== 2'd2)          begin bad++; $display("FAIL hit_lives: got %0d want 2", bus.lives); end
    if (bus.player_visible !== 1'b0) begin bad++; $display("FAIL hit_visible: got %b want 0", bus.player_visible); end
    if (bus.explode_frame !== 2'd0)  begin bad++; $display("FAIL hit_frame: got %0d want 0", bus.explode_frame); end
    step(1'b0, 1'b0);
    total++;
    if (bus.boom !== 1'b0) begin bad++; $display("FAIL hit_boom_width: got %b want 0", bus.boom); end
    $display("test_single_hit: lives=%0d", bus.lives);
  endtask

  task automatic test_edges();
    int bx [4] = '{141, 85, 100, 100};
    int by [4] = '{500, 500, 535, 455};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      set_geom(bx[i], by[i], 1'b1, 95, 15);
      step(1'b1, 1'b0);
      total += 2;
      if (bus.boom !== 1'b0)  begin bad++; $display("FAIL edge_boom_%0d: got %b want 0", i, bus.boom); end
      if (bus.lives !== 2'd3) begin bad++; $display("FAIL edge_lives_%0d: got %0d want 3", i, bus.lives); end
      $display("test_edges: eb_x=%0d eb_y=%0d boom=%b", bx[i], by[i], bus.boom);
    end
    set_geom(140, 500, 1'b1, 95, 15);
    step(1'b1, 1'b0);
    total += 2;
    if (bus.boom !== 1'b1)  begin bad++; $display("FAIL edge_inside_boom: got %b want 1", bus.boom); end
    if (bus.lives !== 2'd2) begin bad++; $display("FAIL edge_inside_lives: got %0d want 2", bus.lives); end
    $display("test_edges: eb_x=140 boom=%b", bus.boom);
  endtask

  task automatic test_no_exist();
    do_reset();
    set_geom(100, 500, 1'b0, 95, 15);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (bus.boom !== 1'b0) begin bad++; $display("FAIL no_exist_boom_%0d: got %b want 0", i, bus.boom); end
    end
    set_geom(100, 400, 1'b1, 95, 0);
    step(1'b1, 1'b0);
    total += 2;
    if (bus.boom !== 1'b0)  begin bad++; $display("FAIL above_boom: got %b want 0", bus.boom); end
    if (bus.lives !== 2'd3) begin bad++; $display("FAIL above_lives: got %0d want 3", bus.lives); end
    $display("test_no_exist: lives=%0d", bus.lives);
  endtask

  task automatic test_timeline();
    do_reset();
    set_geom(100, 500, 1'b1, 95, 15);
    step(1'b1, 1'b0);
    for (int k = 1; k < 32; k++) begin
      step(1'b1, 1'b0);
      total += 3;
      if (bus.explode_frame !== 2'(k / 8)) begin bad++; $display("FAIL frame_%0d: got %0d want %0d", k, bus.explode_frame, k / 8); end
      if (bus.player_visible !== 1'b0) begin bad++; $display("FAIL explode_visible_%0d: got %b want 0", k, bus.player_visible); end
      if (bus.boom !== 1'b0) begin bad++; $display("FAIL explode_boom_%0d: got %b want 0", k, bus.boom); end
    end
    step(1'b1, 1'b0);
    total += 2;
    if (bus.invincible !== 1'b1)     begin bad++; $display("FAIL invuln_enter: got %b want 1", bus.invincible); end
    if (bus.player_visible !== 1'b1) begin bad++; $display("FAIL invuln_visible: got %b want 1", bus.player_visible); end
    $display("test_timeline: invulnerable after 32 ticks");
    for (int k = 1; k <= 120; k++) begin
      step(1'b1, 1'b0);
      total += 2;
      if (bus.invincible !== (k < 120)) begin bad++; $display("FAIL invuln_%0d: got %b want %b", k, bus.invincible, (k < 120)); end
      if (bus.boom !== 1'b0) begin bad++; $display("FAIL invuln_boom_%0d: got %b want 0", k, bus.boom); end
    end
    step(1'b1, 1'b0);
    total += 2;
    if (bus.boom !== 1'b1)  begin bad++; $display("FAIL realive_boom: got %b want 1", bus.boom); end
    if (bus.lives !== 2'd1) begin bad++; $display("FAIL realive_lives: got %0d want 1", bus.lives); end
    $display("test_timeline: alive again, lives=%0d", bus.lives);
  endtask

  task automatic test_game_over();
    do_reset();
    set_geom(100, 500, 1'b1, 95, 15);
    for (int h = 1; h <= 3; h++) begin
      step(1'b1, 1'b0);
      total += 2;
      if (bus.boom !== 1'b1)       begin bad++; $display("FAIL go_boom_%0d: got %b want 1", h, bus.boom); end
      if (bus.lives !== 2'(3 - h)) begin bad++; $display("FAIL go_lives_%0d: got %0d want %0d", h, bus.lives, 3 - h); end
      if (h < 3) run_ticks(152);
      $display("test_game_over: hit %0d lives=%0d", h, bus.lives);
    end
    run_ticks(31);
    total++;
    if (bus.game_over !== 1'b0) begin bad++; $display("FAIL go_early: got %b want 0", bus.game_over); end
    step(1'b1, 1'b0);
    total += 3;
    if (bus.game_over !== 1'b1)      begin bad++; $display("FAIL go_dead: got %b want 1", bus.game_over); end
    if (bus.lives !== 2'd0)          begin bad++; $display("FAIL go_dead_lives: got %0d want 0", bus.lives); end
    if (bus.player_visible !== 1'b0) begin bad++; $display("FAIL go_dead_visible: got %b want 0", bus.player_visible); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (bus.boom !== 1'b0) begin bad++; $display("FAIL dead_boom_%0d: got %b want 0", i, bus.boom); end
    end
    step(1'b0, 1'b1);
    total += 3;
    if (bus.game_over !== 1'b0)      begin bad++; $display("FAIL restart_go: got %b want 0", bus.game_over); end
    if (bus.lives !== 2'd3)          begin bad++; $display("FAIL restart_lives: got %0d want 3", bus.lives); end
    if (bus.player_visible !== 1'b1) begin bad++; $display("FAIL restart_visible: got %b want 1", bus.player_visible); end
    $display("test_game_over: restarted lives=%0d", bus.lives);
    step(1'b1, 1'b1);
    total += 2;
    if (bus.boom !== 1'b1)  begin bad++; $display("FAIL alive_restart_boom: got %b want 1", bus.boom); end
    if (bus.lives !== 2'd2) begin bad++; $display("FAIL alive_restart_lives: got %0d want 2", bus.lives); end
    $display("test_game_over: hit with restart, lives=%0d", bus.lives);
  endtask

  task automatic test_reset_mid_explode();
    int booms;
    do_reset();
    set_geom(100, 500, 1'b1, 95, 15);
    step(1'b1, 1'b0);
    run_ticks(10);
    total++;
    if (bus.explode_frame !== 2'd1) begin bad++; $display("FAIL mid_frame: got %0d want 1", bus.explode_frame); end
    do_reset();
    total += 5;
    if (bus.lives !== 2'd3)          begin bad++; $display("FAIL mid_rst_lives: got %0d want 3", bus.lives); end
    if (bus.player_visible !== 1'b1) begin bad++; $display("FAIL mid_rst_visible: got %b want 1", bus.player_visible); end
    if (bus.explode_frame !== 2'd0)  begin bad++; $display("FAIL mid_rst_frame: got %0d want 0", bus.explode_frame); end
    if (bus.boom !== 1'b0)           begin bad++; $display("FAIL mid_rst_boom: got %b want 0", bus.boom); end
    if (bus.game_over !== 1'b0)      begin bad++; $display("FAIL mid_rst_go: got %b want 0", bus.game_over); end
    booms = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      if (bus.boom === 1'b1) booms++;
    end
    total += 2;
    if (booms != 0)         begin bad++; $display("FAIL no_tick_booms: got %0d want 0", booms); end
    if (bus.lives !== 2'd3) begin bad++; $display("FAIL no_tick_lives: got %0d want 3", bus.lives); end
    step(1'b1, 1'b0);
    total++;
    if (bus.boom !== 1'b1) begin bad++; $display("FAIL post_rst_boom: got %b want 1", bus.boom); end
    $display("test_reset_mid_explode: booms_without_tick=%0d", booms);
  endtask

  initial begin
    rst         = 1'b1;
    bus.tick    = 1'b0;
    bus.restart = 1'b0;
    set_geom(0, 0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    test_reset();
    test_single_hit();
    test_edges();
    test_no_exist();
    test_timeline();
    test_game_over();
    test_reset_mid_explode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
